// File: rtl/module_key_debounce.sv
// Keypad debouncer: turns the scanner's raw key_valid/key_raw into one
// clean press strobe, a held level and one release strobe per key press.
module module_key_debounce #(
   parameter int DEBOUNCE_CYCLES = 270000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_raw,
   output logic [3:0] key_code,
   output logic       key_pulse,
   output logic       key_held,
   output logic       release_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("DEBOUNCE_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      PRESS_CHK,
      HELD,
      RELEASE_CHK
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [3:0]       cand;
   logic [3:0]       cand_n;
   logic [3:0]       code_n;
   logic             pulse_n;
   logic             held_n;
   logic             rel_n;

   logic             press_match;
   logic             held_match;
   logic             cnt_done;

   assign press_match = key_valid && (key_raw == cand);
   assign held_match  = key_valid && (key_raw == key_code);
   assign cnt_done    = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         cand          <= '0;
         key_code      <= '0;
         key_pulse     <= 1'b0;
         key_held      <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         cand          <= cand_n;
         key_code      <= code_n;
         key_pulse     <= pulse_n;
         key_held      <= held_n;
         release_pulse <= rel_n;
      end
   end

   // Strobes default low so each fires for exactly one cycle.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cand_n  = cand;
      code_n  = key_code;
      pulse_n = 1'b0;
      held_n  = key_held;
      rel_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (key_valid) begin
               cand_n  = key_raw;
               cnt_n   = '0;
               state_n = PRESS_CHK;
            end
         end
         PRESS_CHK: begin
            if (!press_match) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else if (cnt_done) begin
               code_n  = cand;
               pulse_n = 1'b1;
               held_n  = 1'b1;
               state_n = HELD;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (!held_match) begin
               cnt_n   = '0;
               state_n = RELEASE_CHK;
            end
         end
         RELEASE_CHK: begin
            // A returning matching sample is contact bounce, not a new press.
            if (held_match) begin
               cnt_n   = '0;
               state_n = HELD;
            end else if (cnt_done) begin
               held_n  = 1'b0;
               rel_n   = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_module_key_debounce.sv
// Scoreboard bench for module_key_debounce with DEBOUNCE_CYCLES=4:
// expected strobes are queued at stimulus time and matched on the negedge.
module tb_module_key_debounce;

   localparam int N = 4;

   typedef struct {
      bit         rel;
      int         cyc;
      logic [3:0] code;
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic       key_valid;
   logic [3:0] key_raw;
   logic [3:0] key_code;
   logic       key_pulse;
   logic       key_held;
   logic       release_pulse;

   ev_t sb[$];
   int  cyc;
   int  n_checks;
   int  n_fail;
   bit  last_press;

   module_key_debounce #(
      .DEBOUNCE_CYCLES(N)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_valid    (key_valid),
      .key_raw      (key_raw),
      .key_code     (key_code),
      .key_pulse    (key_pulse),
      .key_held     (key_held),
      .release_pulse(release_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] raw, input int n);
      for (int i = 0; i < n; i++) begin
         key_valid = v;
         key_raw   = v ? raw : 4'($urandom_range(0, 15));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input bit rel, input int c, input logic [3:0] code);
      ev_t e;
      e.rel  = rel;
      e.cyc  = c;
      e.code = code;
      sb.push_back(e);
   endtask

   task automatic press(input logic [3:0] code, input int n);
      push(1'b0, cyc + 1 + N, code);
      drive(1'b1, code, n);
   endtask

   task automatic release_key(input logic [3:0] code, input int n);
      push(1'b1, cyc + 1 + N, code);
      drive(1'b0, 4'h0, n);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missed_event", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (key_pulse || release_pulse) begin
            ev_t e;
            check("one_strobe", int'(key_pulse && release_pulse), 0);
            check("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("kind", int'(release_pulse), int'(e.rel));
               check("cycle", cyc, e.cyc);
               check("code", int'(key_code), int'(e.code));
               check("held", int'(key_held), int'(!e.rel));
            end
            if (key_pulse) begin
               check("alternate", int'(last_press), 0);
               last_press <= 1'b1;
            end else begin
               last_press <= 1'b0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      last_press = 1'b0;
      key_valid  = 1'b0;
      key_raw    = 4'h0;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_code", int'(key_code), 0);
      check("rst_pulse", int'(key_pulse), 0);
      check("rst_held", int'(key_held), 0);
      check("rst_rel", int'(release_pulse), 0);
      rst_n = 1'b1;
      drive(1'b0, 4'h0, 3);

      // 1: clean press of 5, long hold, release
      press(4'h5, 20);
      check("t1_held", int'(key_held), 1);
      check("t1_code", int'(key_code), 5);
      release_key(4'h5, 10);
      check("t1_rel_held", int'(key_held), 0);

      // 2: bouncing 8, then stable
      drive(1'b1, 4'h8, 2);
      drive(1'b0, 4'h0, 1);
      drive(1'b1, 4'h8, 2);
      drive(1'b0, 4'h0, 1);
      check("t2_no_press", int'(key_held), 0);
      check("t2_code_kept", int'(key_code), 5);
      press(4'h8, 8);
      release_key(4'h8, 10);

      // 3: short drop while holding 3
      press(4'h3, 8);
      drive(1'b0, 4'h0, 2);
      drive(1'b1, 4'h3, 6);
      check("t3_held", int'(key_held), 1);
      check("t3_code", int'(key_code), 3);
      release_key(4'h3, 10);

      // 4: press A, release for 10 cycles
      press(4'hA, 8);
      release_key(4'hA, 10);
      check("t4_held", int'(key_held), 0);
      check("t4_code", int'(key_code), 10);

      // 5: 2 held, switch straight to 7
      press(4'h2, 8);
      push(1'b1, cyc + 1 + N, 4'h2);
      push(1'b0, cyc + 1 + N + 1 + N, 4'h7);
      drive(1'b1, 4'h7, 14);
      check("t5_held", int'(key_held), 1);
      check("t5_code", int'(key_code), 7);
      release_key(4'h7, 10);

      // 6: async reset mid press debounce (cnt=2)
      drive(1'b1, 4'h9, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_code", int'(key_code), 0);
      check("t6_pulse", int'(key_pulse), 0);
      check("t6_held", int'(key_held), 0);
      check("t6_rel", int'(release_pulse), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      last_press = 1'b0;
      rst_n = 1'b1;
      press(4'h9, 10);
      check("t6_after", int'(key_code), 9);
      release_key(4'h9, 10);

      check("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
